// File: rtl/adder_sequencer.sv
// ----------------------------------------------------------------------------
// adder_sequencer
//
// Runs a host-requested job of N adder passes. Each pass issues a one-cycle
// start pulse to the adder state machine and waits for its finished level.
// The pass is then acknowledged with a finish handshake. The sequencer moves
// to the next base address (base + i*ADDR_STRIDE, wrapping modulo 2^ADDR_W).
// A watchdog bounds each pass. Host_Abort ends the job after the pass that is
// currently running.
//
// Ports
//   ADDER_SEQUENCER_Clk      in   clock, all state on rising edge
//   ADDER_SEQUENCER_Reset_n  in   asynchronous active-low reset
//   Host_Start               in   job request, sampled only in IDLE
//   Host_Num_Passes          in   pass count, latched on accepted start
//   Host_Base_Addr           in   pass-0 address, latched on accepted start
//   Host_Abort               in   stop after the current pass completes
//   Host_Done_Ack            in   host acknowledge of Done or Error
//   Adder_Finished           in   adder routine-finished level
//   Adder_Start              out  one-cycle start pulse to the adder
//   Adder_Finished_Ok        out  finish acknowledge to the adder
//   Pass_Addr                out  base address of the current pass
//   Pass_Index               out  0-based index of the current pass
//   Busy                     out  job in progress (LAUNCH/RUN/ACK/NEXT)
//   Done                     out  job complete, waiting for acknowledge
//   Aborted                  out  job completed because of Host_Abort
//   Error                    out  watchdog expired, waiting for acknowledge
// ----------------------------------------------------------------------------
module adder_sequencer #(
  parameter int PASS_W      = 8,
  parameter int ADDR_W      = 12,
  parameter int ADDR_STRIDE = 64,
  parameter int TIMEOUT     = 4096
) (
  input  logic              ADDER_SEQUENCER_Clk,
  input  logic              ADDER_SEQUENCER_Reset_n,
  input  logic              Host_Start,
  input  logic [PASS_W-1:0] Host_Num_Passes,
  input  logic [ADDR_W-1:0] Host_Base_Addr,
  input  logic              Host_Abort,
  input  logic              Host_Done_Ack,
  input  logic              Adder_Finished,
  output logic              Adder_Start,
  output logic              Adder_Finished_Ok,
  output logic [ADDR_W-1:0] Pass_Addr,
  output logic [PASS_W-1:0] Pass_Index,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic              Error
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ACK,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state, w_state_next;
  logic [PASS_W-1:0] r_count, w_count_next;
  logic [PASS_W-1:0] r_index, w_index_next;
  logic [ADDR_W-1:0] r_addr,  w_addr_next;
  logic [WD_W-1:0]   r_wdog,  w_wdog_next;
  logic              r_abort, w_abort_next;
  logic              w_busy;
  logic              w_last_pass;

  assign w_busy      = (r_state == S_LAUNCH) || (r_state == S_RUN) ||
                       (r_state == S_ACK)    || (r_state == S_NEXT);
  assign w_last_pass = (r_index == (r_count - PASS_W'(1)));

  always_ff @(posedge ADDER_SEQUENCER_Clk or negedge ADDER_SEQUENCER_Reset_n) begin
    if (!ADDER_SEQUENCER_Reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= '0;
      r_addr  <= '0;
      r_wdog  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_index <= w_index_next;
      r_addr  <= w_addr_next;
      r_wdog  <= w_wdog_next;
      r_abort <= w_abort_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_index_next = r_index;
    w_addr_next  = r_addr;
    w_wdog_next  = r_wdog;
    w_abort_next = r_abort;

    // Abort is only recorded here; it takes effect at the NEXT decision so
    // that a pass already handed to the adder always runs to completion.
    if (w_busy && Host_Abort) begin
      w_abort_next = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (Host_Start) begin
          w_abort_next = 1'b0;
          if (Host_Num_Passes != '0) begin
            w_count_next = Host_Num_Passes;
            w_index_next = '0;
            w_addr_next  = Host_Base_Addr;
            w_state_next = S_LAUNCH;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        w_wdog_next  = '0;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        w_wdog_next = r_wdog + WD_W'(1);
        // Finishing wins over a watchdog expiring in the same cycle.
        if (Adder_Finished) begin
          w_state_next = S_ACK;
        end else if (r_wdog == WD_LAST) begin
          w_state_next = S_ERROR;
        end
      end
      S_ACK: begin
        if (!Adder_Finished) begin
          w_state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        // An abort arriving in this very cycle still stops the job: the
        // current pass has already completed.
        if (r_abort || Host_Abort || w_last_pass) begin
          w_state_next = S_DONE;
        end else begin
          w_index_next = r_index + PASS_W'(1);
          w_addr_next  = r_addr + STRIDE;
          w_state_next = S_LAUNCH;
        end
      end
      S_DONE: begin
        if (Host_Done_Ack) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERROR: begin
        if (Host_Done_Ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state only.
  assign Adder_Start       = (r_state == S_LAUNCH);
  assign Adder_Finished_Ok = (r_state == S_ACK);
  assign Busy              = w_busy;
  assign Done              = (r_state == S_DONE);
  assign Aborted           = (r_state == S_DONE) && r_abort;
  assign Error             = (r_state == S_ERROR);
  assign Pass_Addr         = r_addr;
  assign Pass_Index        = r_index;

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

  localparam int PASS_W = 8;
  localparam int ADDR_W = 12;
  localparam int STRIDE = 64;
  localparam int TO     = 16;
  localparam int MAXP   = 8;
  localparam int NEVER  = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              Host_Start = 1'b0;
  logic [PASS_W-1:0] Host_Num_Passes = '0;
  logic [ADDR_W-1:0] Host_Base_Addr = '0;
  logic              Host_Abort = 1'b0;
  logic              Host_Done_Ack = 1'b0;
  logic              Adder_Finished = 1'b0;
  logic              Adder_Start;
  logic              Adder_Finished_Ok;
  logic [ADDR_W-1:0] Pass_Addr;
  logic [PASS_W-1:0] Pass_Index;
  logic              Busy;
  logic              Done;
  logic              Aborted;
  logic              Error;

  adder_sequencer #(
    .PASS_W(PASS_W), .ADDR_W(ADDR_W), .ADDR_STRIDE(STRIDE), .TIMEOUT(TO)
  ) dut (
    .ADDER_SEQUENCER_Clk    (clk),
    .ADDER_SEQUENCER_Reset_n(rst_n),
    .Host_Start             (Host_Start),
    .Host_Num_Passes        (Host_Num_Passes),
    .Host_Base_Addr         (Host_Base_Addr),
    .Host_Abort             (Host_Abort),
    .Host_Done_Ack          (Host_Done_Ack),
    .Adder_Finished         (Adder_Finished),
    .Adder_Start            (Adder_Start),
    .Adder_Finished_Ok      (Adder_Finished_Ok),
    .Pass_Addr              (Pass_Addr),
    .Pass_Index             (Pass_Index),
    .Busy                   (Busy),
    .Done                   (Done),
    .Aborted                (Aborted),
    .Error                  (Error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int fails  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Job description, written only by the main process.
  int job_id = 0;
  int cfg_base = 0;
  int cfg_abort = -1;
  int cfg_lat [MAXP];
  int cfg_hold[MAXP];

  // Adder model: raises Finished cfg_lat cycles after the start pulse, keeps
  // it high for cfg_hold cycles after seeing Finished_Ok, then drops it.
  int a_job = -1, a_pass = 0, a_phase = 0, a_rem = 0, a_hold = 0;
  bit a_abort_arm = 1'b0;
  initial forever begin
    @(negedge clk);
    Host_Abort = 1'b0;
    if (!rst_n || Error) begin
      Adder_Finished = 1'b0;
      a_phase = 0;
      a_abort_arm = 1'b0;
    end else begin
      if (a_job != job_id) begin
        a_job = job_id; a_pass = 0; a_phase = 0; Adder_Finished = 1'b0;
      end
      Host_Abort  = a_abort_arm;
      a_abort_arm = 1'b0;
      if (Adder_Start) begin
        a_rem       = cfg_lat[a_pass % MAXP];
        a_hold      = cfg_hold[a_pass % MAXP];
        a_abort_arm = (a_pass == cfg_abort);
        a_phase     = 1;
        a_pass++;
      end else if (a_phase == 1) begin
        a_rem--;
        if (a_rem == 0) begin
          Adder_Finished = 1'b1; a_phase = 2;
        end
      end else if (a_phase == 2) begin
        if (Adder_Finished_Ok) begin
          a_rem = a_hold;
          if (a_rem == 0) begin
            Adder_Finished = 1'b0; a_phase = 0;
          end else begin
            a_phase = 3;
          end
        end
      end else if (a_phase == 3) begin
        a_rem--;
        if (a_rem == 0) begin
          Adder_Finished = 1'b0; a_phase = 0;
        end
      end
    end
  end

  // Compare process: invariants every cycle, pass address/index/spacing on
  // every start pulse against arithmetic expectations.
  int m_job = -1, m_starts = 0, m_last = 0;
  int addr_seen[$];
  initial forever begin
    @(negedge clk);
    if (m_job != job_id) begin
      m_job = job_id; m_starts = 0; addr_seen.delete();
    end
    chk("start_and_finok", int'(Adder_Start && Adder_Finished_Ok), 0);
    chk("status_exclusive", int'(Busy) + int'(Done) + int'(Error) <= 1 ? 1 : 0, 1);
    chk("aborted_outside_done", int'(Aborted && !Done), 0);
    chk("finok_in_error", int'(Error && Adder_Finished_Ok), 0);
    if (!rst_n) begin
      chk("outputs_in_reset", int'({Adder_Start, Adder_Finished_Ok, Pass_Addr, Pass_Index,
                                    Busy, Done, Aborted, Error}), 0);
    end
    if (Adder_Start) begin
      chk("start_busy", int'(Busy), 1);
      chk("start_index", int'(Pass_Index), m_starts);
      chk("start_addr", int'(Pass_Addr), (cfg_base + m_starts * STRIDE) % (1 << ADDR_W));
      if (m_starts > 0) begin
        chk("pass_spacing", cyc - m_last,
            cfg_lat[(m_starts - 1) % MAXP] + cfg_hold[(m_starts - 1) % MAXP] + 3);
      end
      addr_seen.push_back(int'(Pass_Addr));
      m_last = cyc;
      m_starts++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_passes(input int lat, input int hold);
    for (int i = 0; i < MAXP; i++) begin
      cfg_lat[i] = lat; cfg_hold[i] = hold;
    end
  endtask

  int last_lat = 0;
  int last_ab  = 0;

  task automatic run_job(input int n, input int base);
    int exp_starts, exp_err, exp_ab, t0, tend;
    exp_starts = 0; exp_err = 0; exp_ab = 0;
    for (int i = 0; i < n; i++) begin
      exp_starts++;
      if (cfg_lat[i] > TO) begin exp_err = 1; break; end
      if (i == cfg_abort) begin exp_ab = 1; break; end
    end
    job_id++;
    cfg_base = base;
    Host_Num_Passes = PASS_W'(n);
    Host_Base_Addr  = ADDR_W'(base);
    Host_Start = 1'b1;
    t0 = cyc;
    tick();
    Host_Start = 1'b0;
    tend = -1;
    for (int k = 0; k < 3000; k++) begin
      if (Done || Error) begin tend = cyc; break; end
      // Starts and input changes while busy must have no effect.
      Host_Start      = Busy;
      Host_Num_Passes = PASS_W'($urandom);
      Host_Base_Addr  = ADDR_W'($urandom);
      tick();
    end
    Host_Start = 1'b0;
    last_lat = tend - (n == 0 ? t0 : m_last);
    last_ab  = int'(Aborted);
    if (tend < 0) begin
      chk("job_end_bound", 0, 1);
    end else begin
      chk("end_error", int'(Error), exp_err);
      chk("end_done", int'(Done), 1 - exp_err);
      chk("start_count", m_starts, exp_starts);
      if (n == 0) begin
        chk("zero_pass_latency", tend - t0, 1);
        chk("zero_pass_aborted", int'(Aborted), 0);
      end else if (exp_err) begin
        chk("timeout_latency", tend - m_last, TO + 1);
      end else begin
        chk("aborted", int'(Aborted), exp_ab);
        chk("final_index", int'(Pass_Index), exp_starts - 1);
        chk("final_addr", int'(Pass_Addr), (base + (exp_starts - 1) * STRIDE) % (1 << ADDR_W));
      end
      tick(); tick();
      chk("status_held", int'({Done, Error}), exp_err ? 1 : 2);
      Host_Done_Ack = 1'b1;
      tick();
      Host_Done_Ack = 1'b0;
      chk("idle_after_ack", int'({Busy, Done, Error, Aborted}), 0);
    end
    $display("job %0d n=%0d base=0x%03h abort_pass=%0d starts=%0d err=%0d aborted=%0d",
             job_id, n, base, cfg_abort, m_starts, exp_err, exp_ab);
  endtask

  initial begin
    int n, t;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_outputs", int'({Adder_Start, Adder_Finished_Ok, Pass_Addr, Pass_Index,
                               Busy, Done, Aborted, Error}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_release", int'({Busy, Done, Error}), 0);

    // Three passes from 0x100, adder finishes 5 cycles after each start.
    cfg_abort = -1; set_passes(5, 0);
    run_job(3, 'h100);
    chk("lit_seen_count", addr_seen.size(), 3);
    if (addr_seen.size() == 3) begin
      chk("lit_addr0", addr_seen[0], 'h100);
      chk("lit_addr1", addr_seen[1], 'h140);
      chk("lit_addr2", addr_seen[2], 'h180);
    end

    // Zero passes: straight to Done.
    run_job(0, 'h2A0);
    chk("lit_zero_latency", last_lat, 1);

    // Abort during pass 1 with address wrap.
    cfg_abort = 1; set_passes(4, 0);
    run_job(4, 'hFC0);
    chk("lit_abort_aborted", last_ab, 1);
    chk("lit_abort_index", int'(Pass_Index), 1);
    if (addr_seen.size() >= 2) chk("lit_wrap_addr1", addr_seen[1], 'h000);

    // Zero-pass job after an aborted one reports no abort.
    cfg_abort = -1;
    run_job(0, 0);

    // Adder never finishes: Error. Finishing on the last watchdog cycle: no Error.
    set_passes(NEVER, 0);
    run_job(2, 'h010);
    chk("lit_timeout_latency", last_lat, 17);
    set_passes(TO, 0);
    run_job(1, 'h020);

    // Finished held 3 cycles after acknowledge.
    set_passes(2, 3);
    run_job(3, 'h7C0);

    // Reset in the RUN phase of pass 2.
    set_passes(6, 0);
    job_id++;
    cfg_base = 'h300;
    Host_Num_Passes = PASS_W'(4);
    Host_Base_Addr  = ADDR_W'('h300);
    Host_Start = 1'b1;
    tick();
    Host_Start = 1'b0;
    t = 0;
    while (m_starts < 3 && t < 200) begin tick(); t++; end
    chk("reach_pass2", m_starts, 3);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({Adder_Start, Adder_Finished_Ok, Pass_Addr, Pass_Index,
                                        Busy, Done, Aborted, Error}), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("no_start_after_reset", m_starts, 3);
    chk("idle_after_reset", int'({Busy, Done, Error}), 0);
    $display("job %0d n=4 base=0x300 reset during pass 2 starts=%0d", job_id, m_starts);
    set_passes(3, 1);
    run_job(2, 'h040);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < MAXP; i++) begin
        cfg_lat[i]  = int'($urandom_range(1, TO));
        cfg_hold[i] = int'($urandom_range(0, 3));
      end
      if (n > 0 && $urandom_range(0, 5) == 0) cfg_lat[$urandom_range(0, n - 1)] = NEVER;
      cfg_abort = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_job(n, int'($urandom_range(0, (1 << ADDR_W) - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
